// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sa, sb, res, res_next;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic             diff, nb, last;

    function automatic logic diff_bit(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic borrow_bit(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    // The single full-subtractor slice, plus the result register with diff inserted at the MSB
    always_comb begin
        diff     = diff_bit(sa[0], sb[0], borrow);
        nb       = borrow_bit(sa[0], sb[0], borrow);
        last     = (cnt == LAST);
        res_next = res >> 1;
        res_next[WIDTH-1] = diff;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    res    <= res_next;
                    borrow <= nb;
                    cnt    <= cnt + 1'b1;
                    // Final bit: publish the completed result and the last borrow
                    if (last) begin
                        d    <= res_next;
                        bout <= nb;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases, start-while-busy,
// mid-operation reset, and all operand combinations issued back-to-back in random order.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int NCOMB = 1 << (2 * WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             bin = 1'b0;
    logic             busy, done, bout;
    logic [WIDTH-1:0] d;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_done = -1;
    bit b2b = 1'b0;
    logic [WIDTH:0] exp_q[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bout(bout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference: (WIDTH+1)-bit two's complement of a-b-bin gives {bout,d}
    function automatic logic [WIDTH:0] model(input int av, input int bv, input int bi);
        int r;
        r = av - bv - bi;
        return (WIDTH+1)'(r);
    endfunction

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else chk("result", 32'({bout, d}), 32'(exp_q.pop_front()));
            if (b2b && last_done >= 0) chk("done_spacing", 32'(cyc - last_done), 32'(WIDTH + 2));
            last_done = cyc;
        end
    end

    task automatic run_op(input int av, input int bv, input int bi, input bit noise);
        int dc0;
        bit ok;
        dc0 = done_cnt;
        a = WIDTH'(av); b = WIDTH'(bv); bin = bi[0]; start = 1'b1;
        exp_q.push_back(model(av, bv, bi));
        @(posedge clk); #1;
        start = noise;
        a = noise ? WIDTH'(1) : WIDTH'($urandom);
        b = noise ? WIDTH'(9) : WIDTH'($urandom);
        bin = 1'($urandom);
        ok = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (!(busy && !done)) ok = 1'b0;
        end
        chk("busy_window", 32'(ok), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'({busy, done}), 32'd1);
        @(negedge clk);
        chk("back_idle", 32'({busy, done}), 32'd0);
        chk("one_done", 32'(done_cnt - dc0), 32'd1);
        start = 1'b0;
    endtask

    initial begin
        int idx[NCOMB];
        int dc0, j, t, k;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8, 4, 0, 1'b0);
        run_op(4, 8, 0, 1'b0);
        run_op(4, 8, 1, 1'b0);
        run_op(0, 0, 1, 1'b0);
        run_op(15, 15, 0, 1'b0);
        run_op(12, 5, 0, 1'b0);
        run_op(7, 3, 0, 1'b1);
        chk("queue_empty_directed", 32'(exp_q.size()), 32'd0);

        // Reset during the second SHIFT cycle
        dc0 = done_cnt;
        a = WIDTH'(9); b = WIDTH'(2); bin = 1'b0; start = 1'b1;
        exp_q.push_back(model(9, 2, 0));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_d", 32'(d), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        repeat (WIDTH + 3) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cnt - dc0), 32'd0);
        run_op(5, 3, 1, 1'b0);

        // All combinations, shuffled, with start held high
        for (int i = 0; i < NCOMB; i++) idx[i] = i;
        for (int i = NCOMB - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = idx[i]; idx[i] = idx[j]; idx[j] = t;
        end
        dc0 = done_cnt;
        last_done = -1;
        b2b = 1'b1;
        for (int i = 0; i < NCOMB; i++) begin
            k = idx[i];
            a = WIDTH'(k); b = WIDTH'(k >> WIDTH); bin = 1'(k >> (2 * WIDTH));
            start = 1'b1;
            exp_q.push_back(model(k & ((1 << WIDTH) - 1), (k >> WIDTH) & ((1 << WIDTH) - 1), (k >> (2 * WIDTH)) & 1));
            @(posedge clk); #1;
            a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
            repeat (WIDTH + 1) @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (WIDTH + 4) @(negedge clk);
        b2b = 1'b0;
        chk("b2b_done_count", 32'(done_cnt - dc0), 32'(NCOMB));
        chk("queue_empty_final", 32'(exp_q.size()), 32'd0);
        chk("final_idle", 32'({busy, done}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor. Computes d = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Area-reduced sequential counterpart to the parallel ripple-carry adder datapath.
- Used where latency is acceptable and subtraction must share one bit-slice.
- Start/busy/done handshake to a controlling FSM or testbench.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; d/bout valid and newly updated.
- d  output  WIDTH  difference register; holds the last result.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset is sampled at the clock edge only; there is no asynchronous path.
  - rst=1 forces state=IDLE, busy=0, done=0, d=0, bout=0, and clears the shift registers, counter and borrow.
  - rst has priority over start and over any in-flight operation.
  - An in-flight operation is discarded, and no done pulse follows.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - At an edge with start=1: load sa<=a, sb<=b, borrow<=bin, cnt<=0; go to SHIFT.
  - start=0 stays in IDLE.
- SHIFT:
  - busy=1. Each edge computes from the LSBs:
    - diff = sa[0] ^ sb[0] ^ borrow.
    - nb = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow).
  - Register updates on the same edge:
    - sa, sb shift right by 1.
    - The result shift register shifts right with diff entering at bit WIDTH-1.
    - borrow<=nb, cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (the last bit):
    - d<= the completed result, with the final diff bit included.
    - bout<=nb.
    - Go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - The next edge always returns to IDLE.
- start is ignored in SHIFT and DONE. It is not queued; the requester must re-assert it in IDLE.
- Timing:
  - Start accepted at edge E0; busy high after E0.
  - d/bout update at edge E0+WIDTH; done high for the cycle after E0+WIDTH.
  - Back in IDLE after E0+WIDTH+1.
  - Throughput is one operation per WIDTH+2 cycles when start is held high continuously.
- Outputs d and bout are registered and change only on the DONE-entry edge or on reset. Between operations they hold the previous result.
- Operand inputs may change freely after the accepting edge without affecting the result.
- Arithmetic is modulo 2^WIDTH: d = (a - b - bin) mod 2^WIDTH. {bout,d} equals the (WIDTH+1)-bit two's-complement of a-b-bin.
- WIDTH=1: SHIFT lasts one cycle; the same rules apply.
- cnt width is enough to hold WIDTH-1; no wrap occurs inside an operation.

Test Plan:
- a=8, b=4, bin=0, start pulse:
  - busy high for 4 cycles, then done for 1 cycle.
  - d=4'h4, bout=0.
- a=4, b=8, bin=0 -> d=4'hC, bout=1. Same operands with bin=1 -> d=4'hB, bout=1.
- Boundary operand cases:
  - a=0, b=0, bin=1 -> d=4'hF, bout=1.
  - a=F, b=F, bin=0 -> d=0, bout=0.
  - a=C, b=5, bin=0 -> d=4'h7, bout=0.
- Start ignored while busy:
  - Start a=7, b=3; pulse start with a=1, b=9 during SHIFT and during DONE.
  - Result d=4'h4, bout=0; exactly one done pulse; state returns to IDLE.
- Reset mid-operation:
  - Start a=9, b=2, assert rst for one cycle at the 2nd SHIFT cycle.
  - Next cycle: busy=0, done=0, d=0, bout=0, no done pulse afterwards.
  - A new start then completes normally.
- Back-to-back with start held high:
  - Done pulses are exactly WIDTH+2 cycles apart.
  - Randomized a, b, bin are checked against the reference model {bout,d} = a-b-bin, all 512 combinations for WIDTH=4.
